// File: rtl/fifo_read_port_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_port_ctrl
//
// Read-side controller for a synchronous FIFO with one cycle of read latency.
// It issues fifo_rd_en only when a slot in its 2-entry output buffer is
// guaranteed for the word. Each returned word is captured into the buffer and
// presented on a valid/ready stream. The stream sustains one word per cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   enable         permits new FIFO reads
//   fifo_empty     FIFO empty flag
//   fifo_underflow FIFO underflow flag (latched into underflow_err)
//   fifo_data_out  FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en     FIFO read enable (combinational, forced low in reset)
//   m_data         stream data (buffer head)
//   m_valid        stream valid (buffer not empty)
//   m_ready        stream ready from the consumer
//   rd_count       words captured since reset, saturating at all-ones
//   underflow_err  sticky underflow indication, cleared only by rst
// ---------------------------------------------------------------------------
module fifo_read_port_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    // Two-entry output buffer, written at the tail and read at the head.
    logic [FIFO_WIDTH-1:0] slot_q [2];
    logic                  head_q;
    logic                  tail_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  rd_count_q;
    logic [CNT_WIDTH-1:0]  rd_count_d;
    logic                  underflow_err_q;
    logic                  pop;

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = slot_q[head_q];

    // Slots already owed to words: the buffered words plus the word now on
    // fifo_data_out, minus the word leaving this cycle. Because the word in
    // flight is captured at this same edge, this is also the next occupancy.
    // The invariant occ + inflight <= 2 keeps it within 2 bits. A pop
    // implies occ >= 1, so the subtraction never wraps.
    assign occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    // A new read is safe only when at most one slot is owed after this edge.
    // The read's word is then guaranteed a slot when it arrives next cycle.
    assign fifo_rd_en = !rst && enable && !fifo_empty && (occ_d <= 2'd1);

    assign rd_count_d = (rd_count_q == {CNT_WIDTH{1'b1}})
                      ? rd_count_q
                      : rd_count_q + CNT_WIDTH'(1);

    // Per-slot capture. Only the tail slot is written. When the buffer holds
    // two words nothing is in flight, so the head slot is never overwritten
    // while it is being presented.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q[gi] <= '0;
                end else if (inflight_q && (tail_q == 1'(gi))) begin
                    slot_q[gi] <= fifo_data_out;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= 1'b0;
            tail_q          <= 1'b0;
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            rd_count_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            if (pop) begin
                head_q <= ~head_q;
            end
            if (inflight_q) begin
                tail_q     <= ~tail_q;
                rd_count_q <= rd_count_d;
            end
            if (fifo_underflow) begin
                underflow_err_q <= 1'b1;
            end
        end
    end

    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: doc/fifo_read_port_ctrl.md
# fifo_read_port_ctrl

Read-side controller for the synchronous FIFO. It drains the FIFO read port and hides the FIFO's one-cycle read latency by issuing `rd_en` only while it has guaranteed buffer space. Each word is captured and presented on a valid/ready stream toward the downstream consumer. It sits directly on the FIFO's read port and is the consuming counterpart to the write-side stimulus driving `wr_en`/`data_in`.

## Interface
- `FIFO_WIDTH`, 16, width of FIFO data and of the output stream.
- `CNT_WIDTH`, 16, width of the read-word counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new FIFO reads when high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  FIFO read enable.
- `m_data`  out  FIFO_WIDTH  output stream data (buffer head).
- `m_valid`  out  1  output stream valid.
- `m_ready`  in  1  output stream ready.
- `rd_count`  out  CNT_WIDTH  words captured since reset, saturating.
- `underflow_err`  out  1  sticky; set if `fifo_underflow` was ever sampled high.

## Operation
- The state consists of:
  - a 2-entry output buffer (`occ` from 0 to 2, head/tail pointers);
  - the `inflight` register, which is the previous cycle's `fifo_rd_en`;
  - `rd_count`;
  - `underflow_err`.
- `pop` = `m_valid && m_ready`.
- `fifo_rd_en` = `!rst && enable && !fifo_empty && (occ + inflight - pop <= 1)`.
  - It is combinational, and includes the `m_ready` path so that throughput is 1 word/cycle.
- When `inflight` = 1, `fifo_data_out` is written into the buffer tail at that edge, and `rd_count` increments. At all-ones, `rd_count` holds.
- On `pop`, the head advances.
- If capture and pop happen in the same cycle, `occ` is unchanged and both pointers advance.
- `m_valid` = (`occ` != 0). `m_data` = buffer head, and holds stable while `m_valid && !m_ready`.
- Deasserting `enable` stops new reads only. An in-flight word is still captured, and the buffer still drains.
- `underflow_err` is set on any cycle where `fifo_underflow` = 1, and is cleared only by `rst`.
- The sizing invariant `occ + inflight <= 2` always holds. The buffer never overflows, and no read word is lost.

## Timing
- Reset values: `m_valid` 0, `m_data` 0, `rd_count` 0, `underflow_err` 0, `occ` 0, `inflight` 0. `fifo_rd_en` is forced to 0 while `rst` = 1.
- Reset mid-operation discards any in-flight word and all buffered words. FIFO contents are not affected by this block's reset.
- Latency, with `fifo_rd_en` high in cycle N:
  - `fifo_data_out` is valid in cycle N+1;
  - the word is captured at the end of N+1;
  - `m_valid` is high in N+2.
- Sustained rate with `m_ready` held at 1 and the FIFO non-empty is one word per cycle, with no bubbles after the initial 2-cycle fill.
- Backpressure: with `m_ready` = 0, at most 2 reads are issued, then `fifo_rd_en` stays 0 until a pop frees space.
- Empty boundary: the last FIFO word is read in cycle N. `fifo_empty` goes high in N+1, and no read is issued in N+1. No underflow results from this block's own reads.
- Order is strictly preserved: the stream order equals the FIFO pop order.

## Test plan
- **Reset:** hold `rst` 2 cycles with the FIFO non-empty.
  - Required: `fifo_rd_en` = 0, all outputs at reset values, `rd_count` = 0.
- **Streaming:** write 8 words 0x0001..0x0008, hold `m_ready` = 1, `enable` = 1.
  - Required: `m_valid` first high 2 cycles after the first `fifo_rd_en`; stream 0x0001..0x0008 on consecutive cycles; `rd_count` = 8; `fifo_rd_en` low once `fifo_empty` is high.
- **Backpressure:** FIFO holds 5 words, `m_ready` = 0 for 10 cycles.
  - Required: exactly 2 `fifo_rd_en` pulses; `occ` = 2; `m_data` stable at word 1.
  - Then raise `m_ready`: all 5 words are delivered in order, with none lost or duplicated.
- **Enable drop:** deassert `enable` in the cycle `fifo_rd_en` is high.
  - Required: that word is still delivered; no further reads occur; `rd_count` increments by exactly 1.
- **Mid-stream reset:** assert `rst` one cycle while `inflight` = 1 and `occ` = 1.
  - Required: after reset `m_valid` = 0, `rd_count` = 0; the discarded words never appear on the stream.
- **Underflow flag:** pulse `fifo_underflow` for 1 cycle (driven externally).
  - Required: `underflow_err` goes high the next cycle and stays high until `rst`.
